// File: rtl/aes_spi_master.sv
// SPI mode-0 master for the AES encrypt core: sends one 392-bit request
// frame, waits for the cipher to settle, then reads the result frame.
// Ports: clk, reset (sync, active-high); start/busy/done/err host handshake;
//   plaintext/key_len/key request inputs; ciphertext result;
//   sclk/cs/mosi/miso SPI pins (cs active low, MSB first).
module aes_spi_master #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 392,
  parameter int GAP_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [7:0]   key_len,
  input  logic [255:0] key,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [127:0] ciphertext,
  output logic         sclk,
  output logic         cs,
  output logic         mosi,
  input  logic         miso
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [8:0]    BIT_LAST = 9'(FRAME_BITS);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_TX   = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_RX   = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [FRAME_BITS-1:0] sh_q, sh_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [8:0]            bit_q, bit_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  tail_q, tail_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_q, cs_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [127:0]          ct_q, ct_d;
  logic                  key_ok;

  assign key_ok = (sh_q[263:256] == 8'd16) ||
                  (sh_q[263:256] == 8'd24) ||
                  (sh_q[263:256] == 8'd32);

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    tail_d  = tail_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    ct_d    = ct_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sh_d    = {plaintext, key_len, key};
          busy_d  = 1'b1;
          err_d   = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (key_ok) begin
          cs_d    = 1'b0;
          mosi_d  = sh_q[FRAME_BITS-1];
          sclk_d  = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
          tail_d  = 1'b0;
          state_d = S_TX;
        end else begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FIN;
        end
      end
      S_TX, S_RX: begin
        if (cnt_q != DIV_LAST) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = '0;
          if (tail_q) begin
            // trailing low phase done: release the slave
            tail_d = 1'b0;
            cs_d   = 1'b1;
            mosi_d = 1'b0;
            bit_d  = '0;
            if (state_q == S_TX) begin
              gap_d   = '0;
              state_d = S_GAP;
            end else begin
              ct_d    = sh_q[FRAME_BITS-1 -: 128];
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_FIN;
            end
          end else if (!sclk_q) begin
            // rising edge: slave data is stable here
            sclk_d = 1'b1;
            bit_d  = bit_q + 9'd1;
            if (state_q == S_RX)
              sh_d = {sh_q[FRAME_BITS-2:0], miso};
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              tail_d = 1'b1;
              mosi_d = 1'b0;
            end else if (state_q == S_TX) begin
              sh_d   = {sh_q[FRAME_BITS-2:0], 1'b0};
              mosi_d = sh_q[FRAME_BITS-2];
            end else begin
              mosi_d = 1'b0;
            end
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          cs_d    = 1'b0;
          mosi_d  = 1'b0;
          sclk_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_RX;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      tail_q  <= 1'b0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      tail_q  <= tail_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ct_q    <= ct_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign ciphertext = ct_q;
  assign sclk       = sclk_q;
  assign cs         = cs_q;
  assign mosi       = mosi_q;

endmodule

// File: tb/tb_aes_spi_master.sv
// Bench for aes_spi_master: a pin-level SPI slave model captures the request
// frame and returns a response frame; results are checked against a model.
module tb_aes_spi_master;

  localparam int FB  = 392;
  localparam int CD  = 4;
  localparam int GC  = 16;
  localparam int LAT = 2 + 2*FB*2*CD + 2*CD + GC + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [127:0] plaintext = '0;
  logic [7:0]   key_len = '0;
  logic [255:0] key = '0;
  logic         busy, done, err;
  logic [127:0] ciphertext;
  logic         sclk, cs, mosi;
  logic         miso = 1'b0;

  always #5 clk = ~clk;

  aes_spi_master #(.CLK_DIV(CD), .FRAME_BITS(FB), .GAP_CYCLES(GC)) dut (
    .clk(clk), .reset(reset), .start(start),
    .plaintext(plaintext), .key_len(key_len), .key(key),
    .busy(busy), .done(done), .err(err), .ciphertext(ciphertext),
    .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso)
  );

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [391:0] got,
                     input logic [391:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // slave model / pin monitor, sampled away from the active edge
  logic [391:0] resp = '0;
  logic [391:0] capA, capB;
  logic         clr_req = 1'b0;
  logic         cs_p = 1'b1, sclk_p = 1'b0, mosi_p = 1'b0;
  int win, rise_n, gap_n, done_n, viol, cs_low_n;
  int rises [2];

  always @(negedge clk) begin
    if (reset || clr_req) begin
      win = 0; rise_n = 0; gap_n = 0; done_n = 0;
      viol = 0; cs_low_n = 0; capA = '0; capB = '0;
      rises[0] = 0; rises[1] = 0; miso = 1'b0;
    end else begin
      if (cs_p && !cs) begin
        rise_n = 0;
        miso = (win == 1) ? resp[391] : 1'b0;
      end
      if (!cs && sclk && !sclk_p) begin
        if (win == 0) capA = {capA[390:0], mosi};
        else          capB = {capB[390:0], mosi};
        rise_n++;
      end
      if (!cs && !sclk && sclk_p)
        miso = (win == 1 && rise_n < 392) ? resp[391 - rise_n] : 1'b0;
      if (!cs && sclk && (mosi != mosi_p)) viol++;
      if (!cs_p && cs) begin
        if (win < 2) rises[win] = rise_n;
        win++;
      end
      if (cs && win == 1) gap_n++;
      if (!cs) cs_low_n++;
      if (done) done_n++;
    end
    cs_p = cs; sclk_p = sclk; mosi_p = mosi;
  end

  logic [127:0] ct_model = '0;

  function automatic logic [263:0] rnd264();
    logic [263:0] r;
    for (int i = 0; i < 9; i++) r = {r[231:0], 32'($urandom)};
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  task automatic run_op(input string tag, input logic [127:0] pt,
                        input logic [7:0] kl, input logic [255:0] k,
                        input logic [127:0] rct);
    logic legal, got;
    int scyc, dcyc;
    legal = (kl == 8'd16) || (kl == 8'd24) || (kl == 8'd32);
    @(posedge clk); #1;
    plaintext = pt; key_len = kl; key = k;
    resp = {rct, rnd264()};
    clr_req = 1'b1;
    @(negedge clk); #1 clr_req = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; scyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    plaintext = ~pt; key = ~k; key_len = 8'd16;
    got = 1'b0; dcyc = 0;
    for (int i = 0; i < LAT + 100 && !got; i++) begin
      @(negedge clk);
      if (legal && i == 40) start = 1'b1;
      if (legal && i == 41) start = 1'b0;
      if (done) begin got = 1'b1; dcyc = cyc; end
    end
    chk({tag, "/done_seen"}, 392'(got), 392'(1));
    chk({tag, "/latency"}, 392'(dcyc - scyc + 1), 392'(legal ? LAT : 3));
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk({tag, "/fin_start_ignored"}, 392'({busy, done}), 392'(0));
    repeat (4) @(negedge clk);
    if (legal) ct_model = rct;
    chk({tag, "/err"}, 392'(err), 392'(!legal));
    chk({tag, "/ciphertext"}, 392'(ciphertext), 392'(ct_model));
    chk({tag, "/done_width"}, 392'(done_n), 392'(1));
    chk({tag, "/windows"}, 392'(win), 392'(legal ? 2 : 0));
    chk({tag, "/cs_low_cycles"}, 392'(cs_low_n),
        392'(legal ? 2*(FB*2*CD + CD) : 0));
    chk({tag, "/rises_A"}, 392'(rises[0]), 392'(legal ? FB : 0));
    chk({tag, "/rises_B"}, 392'(rises[1]), 392'(legal ? FB : 0));
    chk({tag, "/gap"}, 392'(gap_n), 392'(legal ? GC : 0));
    chk({tag, "/mosi_stable"}, 392'(viol), 392'(0));
    chk({tag, "/frame_A"}, capA, legal ? {pt, kl, k} : 392'(0));
    chk({tag, "/frame_B_zero"}, capB, 392'(0));
  endtask

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K16 = {128'h000102030405060708090a0b0c0d0e0f,
                                  128'h0};
  localparam logic [255:0] K24 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617,
                                  64'h0};
  localparam logic [255:0] K32 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C16 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C24 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C32 = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    logic [7:0] kl;
    logic hit;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset/pins", 392'({busy, done, err, sclk, cs, mosi}), 392'(6'b000010));
    chk("reset/ct", 392'(ciphertext), 392'(0));
    @(posedge clk); #1 reset = 1'b0;

    run_op("aes128", PT, 8'd16, K16, C16);
    run_op("aes192", PT, 8'd24, K24, C24);
    run_op("aes256", PT, 8'd32, K32, C32);
    run_op("klen20", PT, 8'd20, K16, C16);

    for (int n = 0; n < 2; n++) begin
      case ($urandom_range(0, 2))
        0:       kl = 8'd16;
        1:       kl = 8'd24;
        default: kl = 8'd32;
      endcase
      run_op("rand", rnd128(), kl, {rnd128(), rnd128()}, rnd128());
    end
    do kl = 8'($urandom_range(0, 255));
    while (kl == 8'd16 || kl == 8'd24 || kl == 8'd32);
    run_op("rand_bad", rnd128(), kl, {rnd128(), rnd128()}, rnd128());

    @(posedge clk); #1;
    plaintext = PT; key_len = 8'd16; key = K16;
    resp = {C16, rnd264()};
    clr_req = 1'b1;
    @(negedge clk); #1 clr_req = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clk);
      if (win == 0 && rise_n >= 200) hit = 1'b1;
    end
    chk("midrst/bit200", 392'(hit), 392'(1));
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst/pins", 392'({cs, sclk, mosi, busy, done, err}), 392'(6'b100000));
    chk("midrst/ct", 392'(ciphertext), 392'(0));
    ct_model = '0;
    run_op("after_rst", PT, 8'd16, K16, C16);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
